ddr_rw_arbiter: RTL and testbench

DDR_RW_ARBITER -- requirements
Module: ddr_rw_arbiter

---
 rtl/ddr_rw_arbiter.sv | 124 ++++++++++++
 tb/tb_ddr_rw_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rw_arbiter.sv
// Two-channel (write/read) burst arbiter in front of a DDR AXI adapter.
// One burst in flight at a time, tie-break alternates, watchdog aborts stuck bursts.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no burst owned; arbitrates when ddr_init_done is high
// CMD    | command presented, waiting for cmd_ready
// WAIT   | command accepted, waiting for cmd_done (or watchdog expiry)
module ddr_rw_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ddr_init_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              wr_gnt,
  output logic              wr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_gnt,
  output logic              rd_done,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           state;
  logic             last_wr;
  logic [TMR_W-1:0] timer;
  logic             pick_wr;
  logic             timer_tc;

  // On a tie, the channel that was not served last wins.
  assign pick_wr  = wr_req && (!rd_req || !last_wr);
  // Down-counter loaded at grant; reaching zero marks TIMEOUT cycles since grant.
  assign timer_tc = (timer == '0);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      last_wr     <= 1'b0;
      timer       <= '0;
      cmd_valid   <= 1'b0;
      cmd_we      <= 1'b0;
      cmd_addr    <= '0;
      cmd_len     <= '0;
      wr_gnt      <= 1'b0;
      rd_gnt      <= 1'b0;
      wr_done     <= 1'b0;
      rd_done     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      wr_gnt  <= 1'b0;
      rd_gnt  <= 1'b0;
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ddr_init_done && (wr_req || rd_req)) begin
            cmd_we    <= pick_wr;
            cmd_addr  <= pick_wr ? wr_addr : rd_addr;
            cmd_len   <= pick_wr ? wr_len : rd_len;
            cmd_valid <= 1'b1;
            wr_gnt    <= pick_wr;
            rd_gnt    <= !pick_wr;
            timer     <= TMR_LOAD;
            state     <= S_CMD;
          end
        end
        S_CMD: begin
          if (timer_tc) begin
            timeout_err <= 1'b1;
            cmd_valid   <= 1'b0;
            last_wr     <= cmd_we;
            state       <= S_IDLE;
          end else begin
            timer <= timer - 1'b1;
            if (cmd_ready) begin
              cmd_valid <= 1'b0;
              state     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // A completion arriving on the expiry cycle still counts as a completion.
          if (cmd_done) begin
            wr_done <= cmd_we;
            rd_done <= !cmd_we;
            last_wr <= cmd_we;
            state   <= S_IDLE;
          end else if (timer_tc) begin
            timeout_err <= 1'b1;
            last_wr     <= cmd_we;
            state       <= S_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// Randomized scenario bench for ddr_rw_arbiter against a transaction-level model
// (last-served channel, expected fields, expected pulse timing).
module tb_ddr_rw_arbiter;
  localparam int ADDR_W  = 28;
  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst, ddr_init_done;
  logic              wr_req, rd_req, cmd_ready, cmd_done;
  logic [ADDR_W-1:0] wr_addr, rd_addr, cmd_addr;
  logic [LEN_W-1:0]  wr_len, rd_len, cmd_len;
  logic              wr_gnt, wr_done, rd_gnt, rd_done;
  logic              cmd_valid, cmd_we, busy, timeout_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit model_last_wr;  // 1 = write channel served last

  ddr_rw_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ddr_init_done(ddr_init_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_gnt(wr_gnt), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_gnt(rd_gnt), .rd_done(rd_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_done(cmd_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Winner as stated by the arbitration rule: lone requester wins, a tie goes to
  // whichever channel was not served last.
  function automatic bit model_pick_wr(input bit w, input bit r);
    if (w && r) return !model_last_wr;
    return w;
  endfunction

  task automatic wait_grant(output bit got_we, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
      checks++;
      if ((wr_done | rd_done) !== 1'b0) begin
        failures++;
        $display("FAIL stray_done: wr_done=%b rd_done=%b expected 0/0", wr_done, rd_done);
      end
    end while (!(wr_gnt || rd_gnt) && waited < 200);
    checks++;
    if ((wr_gnt ^ rd_gnt) !== 1'b1) begin
      failures++;
      $display("FAIL grant_wait: wr_gnt=%b rd_gnt=%b after %0d cycles, expected exactly one", wr_gnt, rd_gnt, waited);
    end
    got_we = wr_gnt;
  endtask

  // Called in the cycle the grant is visible; finishes in the cycle the done pulse is visible.
  task automatic serve(input bit exp_we, input logic [ADDR_W-1:0] exp_addr, input logic [LEN_W-1:0] exp_len,
                       input int ready_dly, input int done_dly, input bit done_in_cmd);
    for (int i = 0; i <= ready_dly; i++) begin
      checks++;
      if (cmd_valid !== 1'b1 || cmd_we !== exp_we || cmd_addr !== exp_addr || cmd_len !== exp_len ||
          (wr_done | rd_done) !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL cmd_hold: valid=%b we=%b addr=%h len=%0d done=%b%b busy=%b, expected 1 %b %h %0d 00 1",
                 cmd_valid, cmd_we, cmd_addr, cmd_len, wr_done, rd_done, busy, exp_we, exp_addr, exp_len);
      end
      if (i < ready_dly) begin
        cmd_done = done_in_cmd && (i % 7 == 0);
        tick();
        cmd_done = 1'b0;
      end
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b1 || (wr_gnt | rd_gnt) !== 1'b0) begin
      failures++;
      $display("FAIL handshake: valid=%b busy=%b gnt=%b%b, expected 0 1 00", cmd_valid, busy, wr_gnt, rd_gnt);
    end
    for (int i = 0; i < done_dly; i++) begin
      tick();
      checks++;
      if ((wr_done | rd_done) !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL wait_phase: done=%b%b busy=%b, expected 00 1", wr_done, rd_done, busy);
      end
    end
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    checks++;
    if (wr_done !== exp_we || rd_done !== !exp_we || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: wr_done=%b rd_done=%b busy=%b, expected %b %b 0", wr_done, rd_done, busy, exp_we, !exp_we);
    end
    model_last_wr = exp_we;
  endtask

  task automatic test_reset();
    rst = 1'b1; ddr_init_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_len = '0; rd_len = '0; cmd_ready = 1'b0; cmd_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    model_last_wr = 1'b0;
    checks++;
    if ({cmd_valid, cmd_we, wr_gnt, rd_gnt, wr_done, rd_done, busy, timeout_err} !== 8'b0 ||
        cmd_addr !== '0 || cmd_len !== '0) begin
      failures++;
      $display("FAIL reset_state: flags=%b addr=%h len=%0d, expected all zero",
               {cmd_valid, cmd_we, wr_gnt, rd_gnt, wr_done, rd_done, busy, timeout_err}, cmd_addr, cmd_len);
    end
    ddr_init_done = 1'b1;
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    tick();
    checks++;
    if ((wr_done | rd_done | busy) !== 1'b0) begin
      failures++;
      $display("FAIL idle_cmd_done: done=%b%b busy=%b, expected 00 0", wr_done, rd_done, busy);
    end
  endtask

  task automatic test_init_gating();
    bit we; int waited;
    logic [ADDR_W-1:0] a; logic [LEN_W-1:0] l;
    a = ADDR_W'($urandom); l = LEN_W'($urandom);
    ddr_init_done = 1'b0; wr_req = 1'b1; wr_addr = a; wr_len = l;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (wr_gnt !== 1'b0 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
        failures++;
        $display("FAIL init_gate: wr_gnt=%b busy=%b valid=%b at cycle %0d, expected 0 0 0", wr_gnt, busy, cmd_valid, i);
      end
    end
    ddr_init_done = 1'b1;
    wait_grant(we, waited);
    wr_req = 1'b0;
    checks++;
    if (waited !== 1 || we !== 1'b1 || cmd_we !== 1'b1) begin
      failures++;
      $display("FAIL init_release: latency=%0d wr_gnt=%b cmd_we=%b, expected 1 1 1", waited, we, cmd_we);
    end
    serve(1'b1, a, l, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
  endtask

  task automatic test_single_write();
    bit we; int waited;
    wr_req = 1'b1; wr_addr = 28'h0001000; wr_len = 8'd15;
    wait_grant(we, waited);
    wr_req = 1'b0;
    checks++;
    if (we !== 1'b1 || waited !== 1) begin
      failures++;
      $display("FAIL single_write_grant: wr_gnt=%b latency=%0d, expected 1 1", we, waited);
    end
    serve(1'b1, 28'h0001000, 8'd15, 2, 9, 1'b0);
  endtask

  task automatic test_random_bursts();
    bit we, exp_we, w, r; int waited;
    for (int n = 0; n < 10; n++) begin
      int pat;
      pat = $urandom_range(1, 3);
      w = pat[0]; r = pat[1];
      wr_addr = ADDR_W'($urandom); wr_len = LEN_W'($urandom);
      rd_addr = ADDR_W'($urandom); rd_len = LEN_W'($urandom);
      wr_req = w; rd_req = r;
      exp_we = model_pick_wr(w, r);
      wait_grant(we, waited);
      wr_req = 1'b0; rd_req = 1'b0;
      checks++;
      if (we !== exp_we) begin
        failures++;
        $display("FAIL random_winner: burst %0d req=%b%b got wr=%b, expected wr=%b", n, w, r, we, exp_we);
      end
      serve(exp_we, exp_we ? wr_addr : rd_addr, exp_we ? wr_len : rd_len,
            $urandom_range(0, 4), $urandom_range(0, 8), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_tie_alternation();
    bit we, prev_we, exp_we; int waited, prev_cyc;
    rst = 1'b1; tick(); rst = 1'b0;
    model_last_wr = 1'b0;
    wr_addr = ADDR_W'($urandom); wr_len = LEN_W'($urandom);
    rd_addr = ADDR_W'($urandom); rd_len = LEN_W'($urandom);
    wr_req = 1'b1; rd_req = 1'b1;
    prev_we = 1'b0; prev_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      exp_we = model_pick_wr(1'b1, 1'b1);
      wait_grant(we, waited);
      checks++;
      if (we !== exp_we || we !== ((k % 2) == 0)) begin
        failures++;
        $display("FAIL tie_order: grant %0d wr=%b, expected wr=%b", k, we, (k % 2) == 0);
      end
      if (k > 0) begin
        checks++;
        if (cyc - prev_cyc !== 3 || we === prev_we) begin
          failures++;
          $display("FAIL tie_spacing: grant %0d spacing=%0d same_channel=%b, expected 3 0", k, cyc - prev_cyc, we === prev_we);
        end
      end
      prev_we = we; prev_cyc = cyc;
      serve(we, we ? wr_addr : rd_addr, we ? wr_len : rd_len, 0, 0, 1'b0);
    end
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic test_backpressure();
    bit we; int waited;
    wr_addr = ADDR_W'($urandom); wr_len = LEN_W'($urandom); wr_req = 1'b1;
    wait_grant(we, waited);
    wr_req = 1'b0;
    checks++;
    if (we !== 1'b1) begin
      failures++;
      $display("FAIL bp_grant: wr_gnt=%b, expected 1", we);
    end
    serve(1'b1, wr_addr, wr_len, 50, 2, 1'b1);
  endtask

  task automatic test_timeout();
    bit we; int waited, n, d;
    rd_addr = ADDR_W'($urandom); rd_len = LEN_W'($urandom); rd_req = 1'b1;
    wait_grant(we, waited);
    rd_req = 1'b0;
    checks++;
    if (we !== 1'b0 || cmd_we !== 1'b0) begin
      failures++;
      $display("FAIL to_grant: wr=%b cmd_we=%b, expected read", we, cmd_we);
    end
    d = $urandom_range(0, 5);
    n = 0;
    while (timeout_err !== 1'b1 && n < 200) begin
      cmd_ready = (n == d);
      tick();
      n++;
      checks++;
      if ((wr_done | rd_done) !== 1'b0) begin
        failures++;
        $display("FAIL to_no_done: done=%b%b at cycle %0d, expected 00", wr_done, rd_done, n);
      end
    end
    cmd_ready = 1'b0;
    model_last_wr = 1'b0;
    checks++;
    if (n !== TIMEOUT || busy !== 1'b0 || cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL to_expiry: cycles=%0d busy=%b valid=%b, expected %0d 0 0", n, busy, cmd_valid, TIMEOUT);
    end
    wr_addr = ADDR_W'($urandom); wr_len = LEN_W'($urandom); wr_req = 1'b1;
    wait_grant(we, waited);
    wr_req = 1'b0;
    checks++;
    if (we !== 1'b1 || waited !== 1) begin
      failures++;
      $display("FAIL to_regrant: wr=%b latency=%0d, expected 1 1", we, waited);
    end
    serve(1'b1, wr_addr, wr_len, 1, 1, 1'b0);
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL to_sticky: timeout_err=%b, expected 1", timeout_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit we; int waited;
    wr_addr = ADDR_W'($urandom) | 1; wr_len = LEN_W'($urandom) | 1; wr_req = 1'b1;
    wait_grant(we, waited);
    wr_req = 1'b0;
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    model_last_wr = 1'b0;
    checks++;
    if ({cmd_valid, cmd_we, wr_gnt, rd_gnt, wr_done, rd_done, busy, timeout_err} !== 8'b0 ||
        cmd_addr !== '0 || cmd_len !== '0) begin
      failures++;
      $display("FAIL mid_reset: flags=%b addr=%h len=%0d, expected all zero",
               {cmd_valid, cmd_we, wr_gnt, rd_gnt, wr_done, rd_done, busy, timeout_err}, cmd_addr, cmd_len);
    end
    for (int i = 0; i < 10; i++) begin
      cmd_done = (i % 3 == 0);
      tick();
      checks++;
      if ((wr_done | rd_done | busy) !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_idle: done=%b%b busy=%b, expected 00 0", wr_done, rd_done, busy);
      end
    end
    cmd_done = 1'b0;
    rd_addr = ADDR_W'($urandom); rd_len = LEN_W'($urandom);
    wr_req = 1'b1; rd_req = 1'b1;
    wait_grant(we, waited);
    wr_req = 1'b0; rd_req = 1'b0;
    checks++;
    if (we !== model_pick_wr(1'b1, 1'b1)) begin
      failures++;
      $display("FAIL post_reset_tie: wr=%b, expected 1", we);
    end
    serve(1'b1, wr_addr, wr_len, 0, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_init_gating();
    test_single_write();
    test_random_bursts();
    test_tie_alternation();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
